// File: rtl/sdc_cmd_sequencer.sv
// Command sequencer/arbiter in front of the SD command-pin engine: grants the host or
// auto-command requester, drives one command through the engine and retries on CRC/index errors.
module sdc_cmd_sequencer #(
    parameter int MAX_RETRY = 2,
    parameter int RETRY_W   = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    // Requesters hold req high with stable fields until their done pulse; a req still
    // high in the IDLE cycle after done is a new request, and a req dropped mid-command
    // is ignored (the command completes and done still pulses).
    input  logic               i_hostReq,
    input  logic [5:0]         i_hostIndex,
    input  logic [31:0]        i_hostArg,
    input  logic [6:0]         i_hostConfig,
    output logic               o_hostDone,
    input  logic               i_autoReq,
    input  logic [5:0]         i_autoIndex,
    input  logic [31:0]        i_autoArg,
    input  logic [6:0]         i_autoConfig,
    output logic               o_autoDone,
    output logic [4:0]         o_status,
    output logic [RETRY_W-1:0] o_retries,
    output logic [119:0]       o_respOut,
    output logic               o_busy,
    output logic [5:0]         o_cmdIndex,
    output logic [31:0]        o_cmdArgument,
    output logic [6:0]         o_cmdConfig,
    output logic               o_cmdStart,
    input  logic [4:0]         i_interruptEvents,
    input  logic [119:0]       i_response,
    output logic [2:0]         o_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_EVAL      = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    localparam logic [RETRY_W-1:0] LP_MAX_RETRY     = RETRY_W'(MAX_RETRY);
    localparam logic [4:0]         LP_FORCED_STATUS = 5'b00110;
    localparam logic [1:0]         LP_BUSY_LAST     = 2'd2;

    state_t             r_state;
    state_t             w_next;
    logic [RETRY_W-1:0] r_retry_cnt;
    logic [4:0]         r_events;
    logic               r_owner_auto;
    logic [1:0]         r_wb_cnt;
    logic               w_events_nz;
    logic               w_retry;
    logic               w_grant;
    logic               w_force_timeout;

    // events layout: {indexErr, crcErr, timeout, error, ok}
    assign w_events_nz     = |i_interruptEvents;
    assign w_retry         = (r_events[4] | r_events[3]) & ~r_events[2] &
                             (r_retry_cnt < LP_MAX_RETRY);
    assign w_grant         = (r_state == S_IDLE) & (i_autoReq | i_hostReq);
    assign w_force_timeout = (r_state == S_WAIT_BUSY) & w_events_nz & (r_wb_cnt == LP_BUSY_LAST);

    assign o_busy  = (r_state != S_IDLE);
    assign o_state = r_state;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (i_autoReq || i_hostReq) w_next = S_START;
            S_START:     w_next = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (!w_events_nz)         w_next = S_WAIT_DONE;
                else if (w_force_timeout) w_next = S_DONE;
            end
            S_WAIT_DONE: if (w_events_nz) w_next = S_EVAL;
            S_EVAL:      w_next = w_retry ? S_START : S_DONE;
            S_DONE:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_retry_cnt   <= '0;
            r_events      <= '0;
            r_owner_auto  <= 1'b0;
            r_wb_cnt      <= '0;
            o_hostDone    <= 1'b0;
            o_autoDone    <= 1'b0;
            o_status      <= '0;
            o_retries     <= '0;
            o_respOut     <= '0;
            o_cmdIndex    <= '0;
            o_cmdArgument <= '0;
            o_cmdConfig   <= '0;
            o_cmdStart    <= 1'b0;
        end else begin
            o_cmdStart <= (w_next == S_START);
            o_hostDone <= (w_next == S_DONE) & ~r_owner_auto;
            o_autoDone <= (w_next == S_DONE) & r_owner_auto;

            // Fields stay put through retries and until the next grant.
            if (w_grant) begin
                r_owner_auto <= i_autoReq;
                if (i_autoReq) begin
                    o_cmdIndex    <= i_autoIndex;
                    o_cmdArgument <= i_autoArg;
                    o_cmdConfig   <= i_autoConfig;
                end else begin
                    o_cmdIndex    <= i_hostIndex;
                    o_cmdArgument <= i_hostArg;
                    o_cmdConfig   <= i_hostConfig;
                end
            end

            if (r_state == S_START) begin
                r_wb_cnt <= '0;
            end else if (r_state == S_WAIT_BUSY) begin
                r_wb_cnt <= r_wb_cnt + 2'd1;
            end

            if ((r_state == S_WAIT_DONE) && w_events_nz) begin
                r_events <= i_interruptEvents;
            end

            if ((r_state == S_EVAL) && w_retry) begin
                r_retry_cnt <= r_retry_cnt + 1'b1;
            end else if (r_state == S_DONE) begin
                r_retry_cnt <= '0;
            end

            if (w_next == S_DONE) begin
                o_status  <= w_force_timeout ? LP_FORCED_STATUS : r_events;
                o_retries <= r_retry_cnt;
                o_respOut <= i_response;
            end
        end
    end

endmodule

// File: tb/tb_sdc_cmd_sequencer.sv
// Bench for sdc_cmd_sequencer: a behavioural command engine plus a per-command outcome
// model (attempt count, status, retries, latency) derived from the retry/timeout rules.
module tb_sdc_cmd_sequencer;
  localparam int MAX_RETRY = 2;
  localparam int RETRY_W   = 2;

  logic clk, rst;
  logic host_req, host_done, auto_req, auto_done;
  logic [5:0] host_index, auto_index, cmd_index;
  logic [31:0] host_arg, auto_arg, cmd_arg;
  logic [6:0] host_config, auto_config, cmd_config;
  logic [4:0] status, events;
  logic [RETRY_W-1:0] retries;
  logic [119:0] resp_out, response, drv_resp;
  logic busy, cmd_start;
  logic [2:0] state_dbg;

  int n_cmp, n_fail, cyc;

  typedef struct {
    bit got;
    int cycles;
    int first_start;
    int starts;
    logic [4:0] status;
    logic [RETRY_W-1:0] retries;
    logic [119:0] resp;
    int hdone;
    int adone;
    bit fields_ok;
  } obs_t;

  sdc_cmd_sequencer #(.MAX_RETRY(MAX_RETRY), .RETRY_W(RETRY_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_hostReq(host_req), .i_hostIndex(host_index), .i_hostArg(host_arg),
    .i_hostConfig(host_config), .o_hostDone(host_done),
    .i_autoReq(auto_req), .i_autoIndex(auto_index), .i_autoArg(auto_arg),
    .i_autoConfig(auto_config), .o_autoDone(auto_done),
    .o_status(status), .o_retries(retries), .o_respOut(resp_out), .o_busy(busy),
    .o_cmdIndex(cmd_index), .o_cmdArgument(cmd_arg), .o_cmdConfig(cmd_config),
    .o_cmdStart(cmd_start), .i_interruptEvents(events), .i_response(response),
    .o_state(state_dbg)
  );

  // clock / cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // behavioural engine: idle shows nonzero events, busy shows 0 for lat cycles
  logic [4:0] eng_res_q[$];
  int eng_lat_q[$];
  bit eng_stuck, eng_active;
  int eng_cnt;

  initial begin
    events = 5'b00001;
    eng_active = 0;
    eng_stuck = 0;
    eng_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        eng_active = 0;
        events = 5'b00001;
      end else if (!eng_active) begin
        if (cmd_start === 1'b1 && !eng_stuck) begin
          eng_active = 1;
          events = 5'b00000;
          eng_cnt = (eng_lat_q.size() > 0) ? eng_lat_q.pop_front() : 1;
        end
      end else if (eng_cnt == 0) begin
        events = (eng_res_q.size() > 0) ? eng_res_q.pop_front() : 5'b00001;
        eng_active = 0;
      end else begin
        eng_cnt = eng_cnt - 1;
      end
    end
  end

  // monitor: start pulses with their fields, done pulses
  int n_starts, n_host_done, n_auto_done;
  logic [5:0] st_idx_q[$];
  logic [31:0] st_arg_q[$];
  logic [6:0] st_cfg_q[$];
  int st_cyc_q[$];

  initial begin
    n_starts = 0;
    n_host_done = 0;
    n_auto_done = 0;
    forever begin
      @(posedge clk);
      #2;
      if (cmd_start === 1'b1) begin
        n_starts = n_starts + 1;
        st_idx_q.push_back(cmd_index);
        st_arg_q.push_back(cmd_arg);
        st_cfg_q.push_back(cmd_config);
        st_cyc_q.push_back(cyc);
      end
      if (host_done === 1'b1) n_host_done = n_host_done + 1;
      if (auto_done === 1'b1) n_auto_done = n_auto_done + 1;
    end
  end

  // per-attempt engine results and latencies for the next command
  logic [4:0] cur_res[3];
  int cur_lat[3];
  logic [4:0] res_tab[6];

  function automatic obs_t model(input bit stuck, input bit is_auto, input logic [119:0] resp);
    obs_t e;
    int k;
    e = '{default: 0};
    e.got = 1;
    e.fields_ok = 1;
    e.first_start = 1;
    e.resp = resp;
    if (is_auto) e.adone = 1; else e.hdone = 1;
    if (stuck) begin
      e.cycles = 5;
      e.starts = 1;
      e.status = 5'b00110;
      e.retries = '0;
    end else begin
      k = 0;
      while (k < MAX_RETRY && (cur_res[k][4] || cur_res[k][3]) && !cur_res[k][2]) k++;
      e.status = cur_res[k];
      e.retries = RETRY_W'(k);
      e.starts = k + 1;
      e.cycles = 1;
      for (int i = 0; i <= k; i++) e.cycles += cur_lat[i] + 3;
    end
    return e;
  endfunction

  // driver: issue one command, wait for its done, collect observations
  task automatic run_cmd(input bit is_auto, input bit drop_early, input bit stuck,
                         input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] cfg,
                         output obs_t o);
    int c0, s0, h0, a0, g;
    logic [127:0] r128;
    o = '{default: 0};
    g = 0;
    while (busy !== 1'b0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    eng_res_q.delete();
    eng_lat_q.delete();
    for (int i = 0; i < 3; i++) begin
      eng_res_q.push_back(cur_res[i]);
      eng_lat_q.push_back(cur_lat[i]);
    end
    eng_stuck = stuck;
    r128 = {$urandom, $urandom, $urandom, $urandom};
    response = r128[119:0];
    drv_resp = r128[119:0];
    st_idx_q.delete();
    st_arg_q.delete();
    st_cfg_q.delete();
    st_cyc_q.delete();
    s0 = n_starts;
    h0 = n_host_done;
    a0 = n_auto_done;
    if (is_auto) begin
      auto_index = idx; auto_arg = arg; auto_config = cfg; auto_req = 1'b1;
    end else begin
      host_index = idx; host_arg = arg; host_config = cfg; host_req = 1'b1;
    end
    c0 = cyc;
    for (int n = 0; n < 200 && !o.got; n++) begin
      @(negedge clk);
      if (drop_early && cyc == c0 + 1) begin
        host_req = 1'b0;
        auto_req = 1'b0;
      end
      if ((is_auto ? auto_done : host_done) === 1'b1) begin
        o.got = 1;
        o.cycles = cyc - c0;
        host_req = 1'b0;
        auto_req = 1'b0;
      end
    end
    host_req = 1'b0;
    auto_req = 1'b0;
    @(negedge clk);
    o.starts = n_starts - s0;
    o.hdone = n_host_done - h0;
    o.adone = n_auto_done - a0;
    o.status = status;
    o.retries = retries;
    o.resp = resp_out;
    o.first_start = (st_cyc_q.size() > 0) ? st_cyc_q[0] - c0 : -1;
    o.fields_ok = 1;
    foreach (st_idx_q[i])
      if (st_idx_q[i] !== idx || st_arg_q[i] !== arg || st_cfg_q[i] !== cfg) o.fields_ok = 0;
    eng_stuck = 0;
  endtask

  task automatic set_attempts(input logic [4:0] r0, r1, r2, input int l0, l1, l2);
    cur_res[0] = r0; cur_res[1] = r1; cur_res[2] = r2;
    cur_lat[0] = l0; cur_lat[1] = l1; cur_lat[2] = l2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({host_done, auto_done, status, retries, resp_out, busy, cmd_index, cmd_arg,
         cmd_config, cmd_start, state_dbg} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b start=%b status=%b idx=%h, required all zero",
               busy, cmd_start, status, cmd_index);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_host_ok();
    obs_t o, e;
    set_attempts(5'b00001, 5'b00001, 5'b00001, 2, 2, 2);
    run_cmd(0, 0, 0, 6'd17, 32'h0000_1000, 7'h15, o);
    e = model(0, 0, drv_resp);
    n_cmp++; if (o.got !== 1'b1) begin n_fail++; $display("FAIL host_ok_done: no hostDone"); end
    n_cmp++; if (o.first_start !== 1) begin n_fail++; $display("FAIL host_ok_start_cycle: got %0d required 1", o.first_start); end
    n_cmp++; if (o.starts !== 1) begin n_fail++; $display("FAIL host_ok_starts: got %0d required 1", o.starts); end
    n_cmp++; if (o.cycles !== e.cycles) begin n_fail++; $display("FAIL host_ok_latency: got %0d required %0d", o.cycles, e.cycles); end
    n_cmp++; if (o.status !== 5'b00001) begin n_fail++; $display("FAIL host_ok_status: got %b required 00001", o.status); end
    n_cmp++; if (o.retries !== 2'd0) begin n_fail++; $display("FAIL host_ok_retries: got %0d required 0", o.retries); end
    n_cmp++; if (o.resp !== drv_resp) begin n_fail++; $display("FAIL host_ok_resp: got %h required %h", o.resp, drv_resp); end
    n_cmp++; if (o.fields_ok !== 1'b1) begin n_fail++; $display("FAIL host_ok_fields: command fields differ from request"); end
    n_cmp++; if (o.hdone !== 1 || o.adone !== 0) begin n_fail++; $display("FAIL host_ok_done_count: host=%0d auto=%0d required 1/0", o.hdone, o.adone); end
  endtask

  task automatic test_simultaneous();
    int s0, h0, a0, ad_cyc;
    bit got_a, got_h;
    eng_res_q.delete();
    eng_lat_q.delete();
    for (int i = 0; i < 2; i++) begin
      eng_res_q.push_back(5'b00001);
      eng_lat_q.push_back(1);
    end
    st_idx_q.delete(); st_arg_q.delete(); st_cfg_q.delete(); st_cyc_q.delete();
    s0 = n_starts; h0 = n_host_done; a0 = n_auto_done;
    auto_index = 6'd12; auto_arg = 32'h0; auto_config = 7'h01;
    host_index = 6'd33; host_arg = 32'hDEAD_BEEF; host_config = 7'h22;
    auto_req = 1'b1;
    host_req = 1'b1;
    got_a = 0; got_h = 0; ad_cyc = 0;
    for (int n = 0; n < 100 && !got_a; n++) begin
      @(negedge clk);
      if (auto_done === 1'b1) begin got_a = 1; ad_cyc = cyc; auto_req = 1'b0; end
    end
    for (int n = 0; n < 100 && !got_h; n++) begin
      @(negedge clk);
      if (host_done === 1'b1) begin got_h = 1; host_req = 1'b0; end
    end
    auto_req = 1'b0;
    host_req = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (!(got_a && got_h)) begin n_fail++; $display("FAIL simul_done: auto=%0d host=%0d required both", got_a, got_h); end
    n_cmp++; if (st_idx_q.size() < 1 || st_idx_q[0] !== 6'd12) begin n_fail++; $display("FAIL simul_first_index: got %0d starts, first %h required 12", st_idx_q.size(), (st_idx_q.size() > 0) ? st_idx_q[0] : 6'h3f); end
    n_cmp++; if (st_idx_q.size() < 2 || st_idx_q[1] !== 6'd33) begin n_fail++; $display("FAIL simul_second_index: required 33 as second start"); end
    n_cmp++; if (st_cyc_q.size() < 2 || st_cyc_q[1] - ad_cyc !== 2) begin n_fail++; $display("FAIL back_to_back_gap: required 2 cycles from autoDone to next start"); end
    n_cmp++; if (n_auto_done - a0 !== 1 || n_host_done - h0 !== 1) begin n_fail++; $display("FAIL simul_done_count: auto=%0d host=%0d required 1/1", n_auto_done - a0, n_host_done - h0); end
    n_cmp++; if (n_starts - s0 !== 2) begin n_fail++; $display("FAIL simul_starts: got %0d required 2", n_starts - s0); end
  endtask

  task automatic test_crc_retry_ok();
    obs_t o, e;
    set_attempts(5'b01010, 5'b01010, 5'b00001, 1, 3, 2);
    run_cmd(0, 0, 0, 6'd8, 32'h0000_01AA, 7'h05, o);
    e = model(0, 0, drv_resp);
    n_cmp++; if (o.starts !== 3) begin n_fail++; $display("FAIL crc_retry_starts: got %0d required 3", o.starts); end
    n_cmp++; if (o.status !== 5'b00001) begin n_fail++; $display("FAIL crc_retry_status: got %b required 00001", o.status); end
    n_cmp++; if (o.retries !== 2'd2) begin n_fail++; $display("FAIL crc_retry_retries: got %0d required 2", o.retries); end
    n_cmp++; if (o.cycles !== e.cycles) begin n_fail++; $display("FAIL crc_retry_latency: got %0d required %0d", o.cycles, e.cycles); end
    n_cmp++; if (o.fields_ok !== 1'b1) begin n_fail++; $display("FAIL crc_retry_fields: fields changed across retries"); end
  endtask

  task automatic test_crc_all();
    obs_t o;
    set_attempts(5'b01010, 5'b01010, 5'b01010, 2, 1, 1);
    run_cmd(1, 0, 0, 6'd12, 32'h0, 7'h01, o);
    n_cmp++; if (o.starts !== 3) begin n_fail++; $display("FAIL crc_all_starts: got %0d required 3", o.starts); end
    n_cmp++; if (o.status !== 5'b01010) begin n_fail++; $display("FAIL crc_all_status: got %b required 01010", o.status); end
    n_cmp++; if (o.retries !== 2'd2) begin n_fail++; $display("FAIL crc_all_retries: got %0d required 2", o.retries); end
    n_cmp++; if (o.adone !== 1 || o.hdone !== 0) begin n_fail++; $display("FAIL crc_all_done_count: auto=%0d host=%0d required 1/0", o.adone, o.hdone); end
  endtask

  task automatic test_timeout_resp();
    obs_t o;
    set_attempts(5'b00110, 5'b00001, 5'b00001, 3, 1, 1);
    run_cmd(0, 0, 0, 6'd2, 32'h0, 7'h03, o);
    n_cmp++; if (o.starts !== 1) begin n_fail++; $display("FAIL timeout_starts: got %0d required 1", o.starts); end
    n_cmp++; if (o.status !== 5'b00110) begin n_fail++; $display("FAIL timeout_status: got %b required 00110", o.status); end
    n_cmp++; if (o.retries !== 2'd0) begin n_fail++; $display("FAIL timeout_retries: got %0d required 0", o.retries); end
  endtask

  task automatic test_stuck_engine();
    obs_t o;
    set_attempts(5'b00001, 5'b00001, 5'b00001, 1, 1, 1);
    run_cmd(0, 0, 1, 6'd55, 32'h1234_5678, 7'h7F, o);
    n_cmp++; if (o.cycles !== 5) begin n_fail++; $display("FAIL stuck_latency: done at cycle %0d required 5", o.cycles); end
    n_cmp++; if (o.status !== 5'b00110) begin n_fail++; $display("FAIL stuck_status: got %b required 00110", o.status); end
    n_cmp++; if (o.starts !== 1) begin n_fail++; $display("FAIL stuck_starts: got %0d required 1", o.starts); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int h0, a0;
    set_attempts(5'b00001, 5'b00001, 5'b00001, 8, 1, 1);
    eng_res_q.delete(); eng_lat_q.delete();
    eng_res_q.push_back(5'b00001); eng_lat_q.push_back(8);
    h0 = n_host_done; a0 = n_auto_done;
    host_index = 6'd9; host_arg = 32'hCAFE_0009; host_config = 7'h11;
    host_req = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy: got %b required 1", busy); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({host_done, auto_done, status, retries, resp_out, busy, cmd_index, cmd_arg,
         cmd_config, cmd_start, state_dbg} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: busy=%b status=%b idx=%h resp=%h, required all zero",
               busy, status, cmd_index, resp_out);
    end
    host_req = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (n_host_done !== h0 || n_auto_done !== a0) begin n_fail++; $display("FAIL rst_mid_no_done: done pulses %0d/%0d required 0", n_host_done - h0, n_auto_done - a0); end
    set_attempts(5'b00001, 5'b00001, 5'b00001, 2, 1, 1);
    run_cmd(0, 0, 0, 6'd13, 32'h0000_0200, 7'h09, o);
    n_cmp++; if (o.got !== 1'b1 || o.status !== 5'b00001) begin n_fail++; $display("FAIL rst_mid_recover: got done=%0d status=%b required 1/00001", o.got, o.status); end
  endtask

  task automatic test_random();
    obs_t o, e;
    bit is_auto, drop, stuck;
    for (int it = 0; it < 24; it++) begin
      is_auto = 1'($urandom_range(0, 1));
      drop = ($urandom_range(0, 3) == 0);
      stuck = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < 3; i++) begin
        cur_res[i] = res_tab[$urandom_range(0, 5)];
        cur_lat[i] = $urandom_range(1, 6);
      end
      run_cmd(is_auto, drop, stuck, 6'($urandom), $urandom, 7'($urandom), o);
      e = model(stuck, is_auto, drv_resp);
      n_cmp++; if (o.got !== 1'b1 || o.cycles !== e.cycles) begin n_fail++; $display("FAIL rand%0d_latency: got %0d required %0d", it, o.cycles, e.cycles); end
      n_cmp++; if (o.starts !== e.starts || o.first_start !== 1) begin n_fail++; $display("FAIL rand%0d_starts: got %0d at %0d required %0d at 1", it, o.starts, o.first_start, e.starts); end
      n_cmp++; if (o.status !== e.status) begin n_fail++; $display("FAIL rand%0d_status: got %b required %b", it, o.status, e.status); end
      n_cmp++; if (o.retries !== e.retries) begin n_fail++; $display("FAIL rand%0d_retries: got %0d required %0d", it, o.retries, e.retries); end
      n_cmp++; if (o.resp !== e.resp) begin n_fail++; $display("FAIL rand%0d_resp: got %h required %h", it, o.resp, e.resp); end
      n_cmp++; if (o.hdone !== e.hdone || o.adone !== e.adone) begin n_fail++; $display("FAIL rand%0d_done: host=%0d auto=%0d required %0d/%0d", it, o.hdone, o.adone, e.hdone, e.adone); end
      n_cmp++; if (o.fields_ok !== 1'b1) begin n_fail++; $display("FAIL rand%0d_fields: command fields differ from request", it); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    res_tab = '{5'b00001, 5'b01010, 5'b10010, 5'b11010, 5'b00110, 5'b01110};
    host_req = 1'b0; host_index = '0; host_arg = '0; host_config = '0;
    auto_req = 1'b0; auto_index = '0; auto_arg = '0; auto_config = '0;
    response = '0;
    drv_resp = '0;
    test_reset();
    test_host_ok();
    test_simultaneous();
    test_crc_retry_ok();
    test_crc_all();
    test_timeout_resp();
    test_stuck_engine();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sdc_cmd_sequencer.md
# sdc_cmd_sequencer

Command sequencer and arbiter in front of the SD command-pin engine. It accepts command requests from two requesters: the host register interface and the auto-command port used by the data controller, for example for CMD12 stop commands. It grants one requester at a time, drives the command engine's index, argument, config and start signals, tracks the engine through busy and idle, and retries on response CRC or index errors. It returns a latched status and response to whichever requester it granted.

## Interface
- MAX_RETRY, 2: extra attempts after a CRC or index error (0 disables retry).
- RETRY_W, 2: width of the retry counter; must hold MAX_RETRY.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- hostReq  in  1  host request level; fields stable while high.
- hostIndex / hostArg / hostConfig  in  6 / 32 / 7  host command fields.
- hostDone  out  1  one-cycle completion pulse to host.
- autoReq  in  1  auto-command request level.
- autoIndex / autoArg / autoConfig  in  6 / 32 / 7  auto command fields.
- autoDone  out  1  one-cycle completion pulse to auto port.
- status  out  5  events captured from the last completed command: {indexErr, crcErr, timeout, error, ok}.
- retries  out  RETRY_W  retries used by the last completed command.
- respOut  out  120  response captured at completion.
- busy  out  1  high whenever state is not IDLE.
- cmdIndex / cmdArgument / cmdConfig  out  6 / 32 / 7  to the command engine; registered.
- cmdStart  out  1  one-cycle start pulse to the command engine.
- interruptEvents  in  5  engine events; nonzero only while the engine is idle.
- response  in  120  engine response shift register.

## Operation
- **Reset:** all outputs go to 0, the state goes to IDLE and the retry counter clears, asynchronously.
- **IDLE:** samples the requests.
  - autoReq has fixed priority over hostReq.
  - The winner's fields are latched into cmdIndex, cmdArgument and cmdConfig, the owner flag is set, and the state moves to START.
- **START:** cmdStart=1 for exactly one cycle, then WAIT_BUSY.
- **WAIT_BUSY:** waits for interruptEvents==0, which shows the engine has left idle, then WAIT_DONE.
  - If interruptEvents is still nonzero 4 cycles after START, completion is forced with status=5'b00110 (timeout+error) and no retry.
- **WAIT_DONE:** waits for interruptEvents!=0, then captures interruptEvents into an internal event register and moves to EVAL.
- **EVAL:**
  - If (crcErr or indexErr) and timeout=0 and the retry counter < MAX_RETRY: increment the counter and return to START. The fields are unchanged.
  - Otherwise go to DONE.
- **DONE:**
  - status ← captured events; retries ← counter; respOut ← response.
  - Pulse hostDone or autoDone according to the owner.
  - Clear the counter and return to IDLE.
- cmdIndex, cmdArgument and cmdConfig are held constant from the latch until the return to IDLE. The engine reads cmdConfig up to its final state.
- A requester that drops its req mid-command is ignored. The command completes and done still pulses.
- A requester must drop req on the cycle its done pulse is seen. A req still high in the IDLE cycle after done is a new request.
- A timeout is never retried.

## Timing
- **Cycle numbering:** cycle 0 = IDLE with a request high.
  - Cycle 1 = START, with the fields valid at the outputs and cmdStart=1.
  - Cycle 2 = WAIT_BUSY (the engine shows 0 events from cycle 2).
- **Completion:** first cycle with interruptEvents!=0 = E. E+1 = EVAL; E+2 = DONE, done pulse high, status, retries and respOut valid.
- **Retry:** EVAL → START in one cycle; each retry adds 2 cycles plus the engine time.
- **Back-to-back:** minimum gap from a done pulse to the next cmdStart is 2 cycles (DONE → IDLE → START).
- **Simultaneous requests in IDLE:** auto is served; host is served in the following IDLE if hostReq is still high.
- status, retries and respOut hold their values until the next DONE.

## Test plan
- **Single host command, engine answers OK:** hostReq with index=17, arg=0x00001000. Expect cmdStart exactly 1 cycle at cycle 1, then hostDone at E+2, status=5'b00001, retries=0, respOut=engine response.
- **Simultaneous hostReq and autoReq (index 12):** expect the first cmdIndex=12 and autoDone first. Host is served second with no lost request, and hostDone fires once.
- **CRC error on the first two attempts, OK on the third, MAX_RETRY=2:** expect 3 cmdStart pulses, status=5'b00001, retries=2.
- **CRC error on every attempt:** expect 3 starts, then done with status=5'b01010, retries=2.
- **Timeout response 5'b00110:** expect no retry, 1 start only, status=5'b00110.
- **Reset asserted during WAIT_DONE:**
  - Expect all outputs 0 immediately and no done pulse.
  - After reset release, a new hostReq completes normally.
- **Engine never leaves idle:** expect a forced done 4 cycles after START with status=5'b00110.
